mux_nx1_stream: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer; successor to the combinational 4:1 mux.
- Adds a registered output with a valid/ready handshake.
- Two modes: manual select, and auto round-robin scan over a channel-enable mask.
- Sits between parallel sample sources and a single serial consumer, for example a display or UART framer.

---
 rtl/mux_nx1_stream.sv | 154 +++++++++++++++
 tb/tb_mux_nx1_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-channel, W-bit registered multiplexer with a valid/ready
// output. Manual mode forwards the channel chosen by sel; scan mode walks the
// enabled channels round-robin, one beat per accepted transfer.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   mode        0 = manual select, 1 = round-robin scan
//   sel         channel index used in manual mode
//   ch_mask     per-channel enable, bit i enables channel i
//   din         packed inputs, channel i at [i*W +: W]
//   out_ready   consumer accepts the current beat
//   out_valid   dout/dout_ch hold a valid beat
//   dout        selected channel data
//   dout_ch     index of the channel held in dout
module mux_nx1_stream #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [N_CH-1:0]     ch_mask,
    input  logic [N_CH*W-1:0]   din,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [W-1:0]        dout,
    output logic [SEL_W-1:0]    dout_ch
);

    // One extra bit so start+offset can exceed N_CH-1 before wrapping.
    localparam int unsigned      IDX_W    = SEL_W + 1;
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     dout_q,      dout_d;
    logic [SEL_W-1:0] dout_ch_q,   dout_ch_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;
    logic             mode_q,      mode_d;

    logic             load_c;
    logic             scan_entry_c;
    logic [SEL_W-1:0] scan_start_c;
    logic [IDX_W-1:0] cand_c;
    logic             scan_hit_c;
    logic [SEL_W-1:0] scan_ch_c;
    logic             manual_ok_c;
    logic [SEL_W-1:0] pick_ch_c;
    logic [W-1:0]     pick_data_c;

    // Output register accepts new data when empty or being drained.
    assign load_c = !out_valid_q || out_ready;

    // mode_q holds the mode of the last load, so an entry into scan mode
    // is still seen at the first load even if mode flipped during a stall.
    assign scan_entry_c = mode && !mode_q;
    assign scan_start_c = scan_entry_c ? '0 : ptr_q;

    // Manual select is valid only for an in-range, enabled channel.
    always_comb begin : manual_check
        manual_ok_c = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i) && ch_mask[i]) begin
                manual_ok_c = 1'b1;
            end
        end
    end

    // Rotating priority search: first enabled channel at or after scan_start_c.
    always_comb begin : scan_search
        scan_hit_c = 1'b0;
        scan_ch_c  = '0;
        cand_c     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand_c = IDX_W'(scan_start_c) + IDX_W'(k);
            if (cand_c >= N_IDX) begin
                cand_c = cand_c - N_IDX;
            end
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!scan_hit_c && cand_c == IDX_W'(i) && ch_mask[i]) begin
                    scan_hit_c = 1'b1;
                    scan_ch_c  = SEL_W'(i);
                end
            end
        end
    end

    // Data mux; out-of-range indices read as zero.
    assign pick_ch_c = mode ? scan_ch_c : sel;

    always_comb begin : data_mux
        pick_data_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (pick_ch_c == SEL_W'(i)) begin
                pick_data_c = din[i*W +: W];
            end
        end
    end

    // Next-state for output register, scan pointer and mode history.
    always_comb begin : next_state
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        dout_ch_d   = dout_ch_q;
        ptr_d       = ptr_q;
        mode_d      = mode_q;

        if (load_c) begin
            mode_d = mode;
            if (!mode) begin
                if (manual_ok_c) begin
                    out_valid_d = 1'b1;
                    dout_d      = pick_data_c;
                    dout_ch_d   = sel;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (scan_hit_c) begin
                out_valid_d = 1'b1;
                dout_d      = pick_data_c;
                dout_ch_d   = scan_ch_c;
                ptr_d       = ({1'b0, scan_ch_c} == LAST_IDX) ? '0
                                                              : scan_ch_c + SEL_W'(1);
            end else begin
                // Nothing enabled: pointer holds (or settles at 0 on scan entry).
                out_valid_d = 1'b0;
                ptr_d       = scan_start_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            dout_ch_q   <= '0;
            ptr_q       <= '0;
            mode_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            dout_ch_q   <= dout_ch_d;
            ptr_q       <= ptr_d;
            mode_q      <= mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign dout_ch   = dout_ch_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream (N_CH=4, W=8). Expected beats are queued
// as stimulus is issued; a negedge monitor pops one per accepted transfer.
module tb_mux_nx1_stream;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned SEL_W = 2;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [SEL_W-1:0] ch;
    } beat_t;

    logic               clk;
    logic               rst_n;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [N_CH-1:0]    ch_mask;
    logic [N_CH*W-1:0]  din;
    logic               out_ready;
    logic               out_valid;
    logic [W-1:0]       dout;
    logic [SEL_W-1:0]   dout_ch;

    beat_t sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Hand-computed beat sequences.
    int t3a_ch[6]  = '{0, 1, 2, 3, 0, 1};
    int t3a_dat[6] = '{'h11, 'h22, 'h33, 'h44, 'h11, 'h22};
    int t3b_ch[4]  = '{1, 3, 1, 3};
    int t3b_dat[4] = '{'h22, 'h44, 'h22, 'h44};

    mux_nx1_stream #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .ch_mask   (ch_mask),
        .din       (din),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .dout_ch   (dout_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [W-1:0] data, input logic [SEL_W-1:0] ch);
        beat_t b;
        b.data = data;
        b.ch   = ch;
        sb_q.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] val);
        din[ch*W +: W] = val;
    endtask

    // Monitor: every accepted transfer must match the oldest queued beat.
    initial begin : monitor
        beat_t exp_b;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got ch=%0d data=0x%0h, expected no beat",
                             dout_ch, dout);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("beat_data", 32'(dout), 32'(exp_b.data));
                    check("beat_ch", 32'(dout_ch), 32'(exp_b.ch));
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        ch_mask   = 4'b1111;
        out_ready = 1'b1;
        din       = {8'h44, 8'h33, 8'h22, 8'h11};
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ch", 32'(dout_ch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: manual sweep
        for (int i = 0; i < 4; i++) begin
            sel = SEL_W'(i);
            expect_beat(W'(t3a_dat[i]), SEL_W'(i));
            step();
            check("t1_valid", 32'(out_valid), 32'd1);
        end

        // 2: masked manual select, then a valid one
        ch_mask = 4'b1011;
        sel     = 2'd2;
        step();
        check("t2_masked_valid", 32'(out_valid), 32'd0);
        sel = 2'd3;
        expect_beat(8'h44, 2'd3);
        step();
        check("t2_valid", 32'(out_valid), 32'd1);

        // 3: scan entry with all enabled, re-enter with 1010
        mode    = 1'b1;
        ch_mask = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            expect_beat(W'(t3a_dat[i]), SEL_W'(t3a_ch[i]));
            step();
        end
        mode = 1'b0;
        sel  = 2'd1;
        expect_beat(8'h22, 2'd1);
        step();
        mode    = 1'b1;
        ch_mask = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            expect_beat(W'(t3b_dat[i]), SEL_W'(t3b_ch[i]));
            step();
        end

        // 4: backpressure while holding channel 1
        ch_mask = 4'b1111;
        expect_beat(8'h11, 2'd0);
        step();
        expect_beat(8'h22, 2'd1);
        step();
        out_ready = 1'b0;
        set_ch(1, 8'h99);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data", 32'(dout), 32'h22);
            check("t4_hold_ch", 32'(dout_ch), 32'd1);
        end
        out_ready = 1'b1;
        expect_beat(8'h33, 2'd2);
        step();
        set_ch(1, 8'h22);

        // 5: everything masked, then only channel 2
        ch_mask = 4'b0000;
        step();
        check("t5_empty_valid", 32'(out_valid), 32'd0);
        step();
        check("t5_empty_valid2", 32'(out_valid), 32'd0);
        ch_mask = 4'b0100;
        expect_beat(8'h33, 2'd2);
        step();
        check("t5_restore_valid", 32'(out_valid), 32'd1);

        // 6: asynchronous reset mid-scan
        ch_mask = 4'b1111;
        expect_beat(8'h44, 2'd3);
        step();
        #6;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_dout", 32'(dout), 32'd0);
        check("t6_rst_ch", 32'(dout_ch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_beat(8'h11, 2'd0);
        step();
        check("t6_first_ch", 32'(dout_ch), 32'd0);
        check("t6_first_dout", 32'(dout), 32'h11);

        // Drain: stop producing beats and confirm every expected beat was seen.
        ch_mask = 4'b0000;
        step();
        step();
        check("end_valid", 32'(out_valid), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
